// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// lcd_write_arbiter : two-FIFO round-robin arbiter for the LCD char port
// Rev 1.0
// ============================================================================

module lcd_warb_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_head,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr;
    logic [c_AW-1:0]   r_rd;
    logic [c_AW:0]     r_level;
    logic              r_ovf;
    logic              w_pop;
    logic              w_push_ok;

    assign w_pop     = i_pop && (r_level != '0);
    // A full FIFO still accepts when its head leaves in the same cycle
    assign w_push_ok = i_push && ((r_level != c_FULL) || w_pop);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (i_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head     = r_mem[r_rd];
    assign o_level    = r_level;
    assign o_overflow = r_ovf;
endmodule

module lcd_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          kb_valid,
    input  logic [DATA_W-1:0]             kb_data,
    input  logic                          cpu_valid,
    input  logic [DATA_W-1:0]             cpu_data,
    input  logic                          lcd_busy,
    output logic                          lcd_we,
    output logic [DATA_W-1:0]             lcd_data,
    output logic                          grant_cpu,
    output logic                          kb_overflow,
    output logic                          cpu_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   kb_level,
    output logic [$clog2(FIFO_DEPTH):0]   cpu_level
);
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_kb_v;
    logic [DATA_W-1:0] r_kb_d;
    logic              r_cpu_v;
    logic [DATA_W-1:0] r_cpu_d;
    logic              r_last_cpu;
    logic              r_lcd_we;
    logic [DATA_W-1:0] r_lcd_data;
    logic              r_grant_cpu;
    logic              w_pop_kb;
    logic              w_pop_cpu;
    logic [DATA_W-1:0] w_kb_head;
    logic [DATA_W-1:0] w_cpu_head;
    logic              w_kb_ne;
    logic              w_cpu_ne;

    // Input capture stage: a push lands in its FIFO one edge after the strobe
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_kb_v  <= 1'b0;
            r_kb_d  <= '0;
            r_cpu_v <= 1'b0;
            r_cpu_d <= '0;
        end else begin
            r_kb_v  <= kb_valid;
            r_kb_d  <= kb_data;
            r_cpu_v <= cpu_valid;
            r_cpu_d <= cpu_data;
        end
    end

    lcd_warb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_kb_fifo (
        .clock      (clock),
        .resetn     (resetn),
        .i_push     (r_kb_v),
        .i_data     (r_kb_d),
        .i_pop      (w_pop_kb),
        .o_head     (w_kb_head),
        .o_level    (kb_level),
        .o_overflow (kb_overflow)
    );

    lcd_warb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_cpu_fifo (
        .clock      (clock),
        .resetn     (resetn),
        .i_push     (r_cpu_v),
        .i_data     (r_cpu_d),
        .i_pop      (w_pop_cpu),
        .o_head     (w_cpu_head),
        .o_level    (cpu_level),
        .o_overflow (cpu_overflow)
    );

    assign w_kb_ne  = (kb_level != '0);
    assign w_cpu_ne = (cpu_level != '0);

    always_comb begin
        w_next    = r_state;
        w_pop_kb  = 1'b0;
        w_pop_cpu = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the side not granted last wins; r_last_cpu resets to 0 so cpu wins first
                if (w_cpu_ne && (!w_kb_ne || !r_last_cpu)) begin
                    w_pop_cpu = 1'b1;
                    w_next    = S_ISSUE;
                end else if (w_kb_ne) begin
                    w_pop_kb  = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!lcd_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_lcd_we    <= 1'b0;
            r_lcd_data  <= '0;
            r_grant_cpu <= 1'b0;
            r_last_cpu  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_lcd_we <= (w_next == S_ISSUE);
            if (w_pop_cpu) begin
                r_lcd_data  <= w_cpu_head;
                r_grant_cpu <= 1'b1;
            end else if (w_pop_kb) begin
                r_lcd_data  <= w_kb_head;
                r_grant_cpu <= 1'b0;
            end
            if ((r_state == S_ISSUE) && !lcd_busy) begin
                r_last_cpu <= r_grant_cpu;
            end
        end
    end

    assign lcd_we    = r_lcd_we;
    assign lcd_data  = r_lcd_data;
    assign grant_cpu = r_grant_cpu;
endmodule
`default_nettype wire
